// File: rtl/fantasticfft_pkg.sv
// Shared types and constants for the 64-point DFT path (dft64, sample framer, bin streamer).
package fantasticfft_pkg;

  localparam int DFT_DATA_W = 16;
  localparam int FRAME_ROWS = 8;
  localparam int FRAME_COLS = 8;
  localparam int NBINS      = FRAME_ROWS * FRAME_COLS;
  localparam int BIN_W      = $clog2(NBINS);

  typedef logic [FRAME_ROWS-1:0][FRAME_COLS-1:0][DFT_DATA_W-1:0] bin_frame_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } rd_state_e;

endpackage

// File: rtl/dft64_frame_buf.sv
// One frame of real/imag bin storage: whole-frame write, single-bin read where bin n = r + NROW*c.
module dft64_frame_buf
  import fantasticfft_pkg::*;
#(
  parameter int DATA_W = DFT_DATA_W,
  parameter int NROW   = FRAME_ROWS,
  parameter int NCOL   = FRAME_COLS
) (
  input  logic                                 clk,
  input  logic                                 we,
  input  logic [NROW-1:0][NCOL-1:0][DATA_W-1:0] wr_real,
  input  logic [NROW-1:0][NCOL-1:0][DATA_W-1:0] wr_imag,
  input  logic [BIN_W-1:0]                     rd_bin,
  output logic [DATA_W-1:0]                    rd_real,
  output logic [DATA_W-1:0]                    rd_imag
);

  localparam int RW = $clog2(NROW);

  logic [NROW-1:0][NCOL-1:0][DATA_W-1:0] mem_real;
  logic [NROW-1:0][NCOL-1:0][DATA_W-1:0] mem_imag;
  logic [RW-1:0]       row;
  logic [BIN_W-RW-1:0] col;

  // Power-of-two rows: low bits pick the row, high bits the column.
  assign row = rd_bin[RW-1:0];
  assign col = rd_bin[BIN_W-1:RW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_real <= wr_real;
      mem_imag <= wr_imag;
    end
  end

  assign rd_real = mem_real[row][col];
  assign rd_imag = mem_imag[row][col];

endmodule

// File: rtl/dft64_bin_streamer.sv
// Ping-pong capture of DFT bin frames and in-order valid/ready streaming of the 64 bins.
module dft64_bin_streamer
  import fantasticfft_pkg::*;
#(
  parameter int DATA_W = DFT_DATA_W,
  parameter int NROW   = FRAME_ROWS,
  parameter int NCOL   = FRAME_COLS
) (
  input  logic                                 clk,
  input  logic                                 sreset,
  input  logic                                 frame_valid,
  input  logic [NROW-1:0][NCOL-1:0][DATA_W-1:0] frame_real,
  input  logic [NROW-1:0][NCOL-1:0][DATA_W-1:0] frame_imag,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic [DATA_W-1:0]                    m_real,
  output logic [DATA_W-1:0]                    m_imag,
  output logic [BIN_W-1:0]                     m_bin,
  output logic                                 m_last,
  output logic                                 overflow,
  output logic [7:0]                           drop_count,
  output logic                                 busy
);

  rd_state_e        rd_state, state_nxt;
  logic [1:0]       buf_full, full_eff, full_nxt, we;
  logic             wr_sel, rd_sel, rd_sel_nxt;
  logic [BIN_W-1:0] bin_cnt, bin_nxt;
  logic             hs, last_hs, accept, drop;
  logic [1:0][DATA_W-1:0] rd_real, rd_imag;
  logic [DATA_W-1:0] nxt_real, nxt_imag;

  for (genvar i = 0; i < 2; i++) begin : g_buf
    dft64_frame_buf #(
      .DATA_W (DATA_W),
      .NROW   (NROW),
      .NCOL   (NCOL)
    ) u_buf (
      .clk     (clk),
      .we      (we[i]),
      .wr_real (frame_real),
      .wr_imag (frame_imag),
      .rd_bin  (bin_nxt),
      .rd_real (rd_real[i]),
      .rd_imag (rd_imag[i])
    );
  end

  // A buffer drained this cycle is already free for an arriving frame.
  always_comb begin
    hs       = (rd_state == STREAM) && m_ready;
    last_hs  = hs && (bin_cnt == BIN_W'(NBINS - 1));
    full_eff = buf_full;
    if (last_hs) full_eff[rd_sel] = 1'b0;
    accept   = frame_valid && !full_eff[wr_sel];
    drop     = frame_valid && !accept;
    we       = 2'b00;
    if (accept) we[wr_sel] = 1'b1;
    full_nxt   = full_eff | we;
    rd_sel_nxt = rd_sel ^ last_hs;
    bin_nxt    = last_hs ? '0 : bin_cnt + BIN_W'(hs);
    state_nxt  = full_nxt[rd_sel_nxt] ? STREAM : IDLE;
  end

  // A frame landing in the buffer about to be read always starts at bin 0, so bypass its [0][0].
  always_comb begin
    nxt_real = '0;
    nxt_imag = '0;
    if (state_nxt == STREAM) begin
      if (we[rd_sel_nxt]) begin
        nxt_real = frame_real[0][0];
        nxt_imag = frame_imag[0][0];
      end else begin
        nxt_real = rd_real[rd_sel_nxt];
        nxt_imag = rd_imag[rd_sel_nxt];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sreset) begin
      rd_state   <= IDLE;
      buf_full   <= 2'b00;
      wr_sel     <= 1'b0;
      rd_sel     <= 1'b0;
      bin_cnt    <= '0;
      m_real     <= '0;
      m_imag     <= '0;
      m_last     <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= 8'd0;
      busy       <= 1'b0;
    end else begin
      rd_state <= state_nxt;
      buf_full <= full_nxt;
      wr_sel   <= wr_sel ^ accept;
      rd_sel   <= rd_sel_nxt;
      bin_cnt  <= bin_nxt;
      m_real   <= nxt_real;
      m_imag   <= nxt_imag;
      m_last   <= (state_nxt == STREAM) && (bin_nxt == BIN_W'(NBINS - 1));
      overflow <= drop;
      if (drop && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
      busy     <= |full_nxt;
    end
  end

  assign m_valid = (rd_state == STREAM);
  assign m_bin   = bin_cnt;

endmodule

// File: tb/tb_dft64_bin_streamer.sv
// Directed bench for dft64_bin_streamer with a frame-queue reference model checked every cycle.
module tb_dft64_bin_streamer;

  logic                    clk = 1'b0;
  logic                    sreset;
  logic                    frame_valid;
  logic [7:0][7:0][15:0]   frame_real;
  logic [7:0][7:0][15:0]   frame_imag;
  logic                    m_valid;
  logic                    m_ready;
  logic [15:0]             m_real;
  logic [15:0]             m_imag;
  logic [5:0]              m_bin;
  logic                    m_last;
  logic                    overflow;
  logic [7:0]              drop_count;
  logic                    busy;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;
  int ovf_pulses = 0;

  // reference model: queue of accepted frames, flattened in bin order
  logic [15:0] qr[$];
  logic [15:0] qi[$];
  int nfr = 0;
  int idx = 0;
  bit mdl_ovf = 1'b0;
  int mdl_drops = 0;

  always #5 clk = ~clk;

  dft64_bin_streamer dut (
    .clk         (clk),
    .sreset      (sreset),
    .frame_valid (frame_valid),
    .frame_real  (frame_real),
    .frame_imag  (frame_imag),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_real      (m_real),
    .m_imag      (m_imag),
    .m_bin       (m_bin),
    .m_last      (m_last),
    .overflow    (overflow),
    .drop_count  (drop_count),
    .busy        (busy)
  );

  task automatic chk(input string name, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  always @(posedge clk) begin
    if (sreset) begin
      qr.delete();
      qi.delete();
      nfr = 0;
      idx = 0;
      mdl_ovf = 1'b0;
      mdl_drops = 0;
    end else begin
      if (nfr > 0 && m_ready) begin
        if (idx == 63) begin
          repeat (64) begin
            void'(qr.pop_front());
            void'(qi.pop_front());
          end
          nfr--;
          idx = 0;
        end else begin
          idx++;
        end
      end
      mdl_ovf = 1'b0;
      if (frame_valid) begin
        if (nfr < 2) begin
          for (int n = 0; n < 64; n++) begin
            qr.push_back(frame_real[n % 8][n / 8]);
            qi.push_back(frame_imag[n % 8][n / 8]);
          end
          nfr++;
        end else begin
          mdl_ovf = 1'b1;
          if (mdl_drops < 255) mdl_drops++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_valid", m_valid, nfr > 0);
      chk("busy", busy, nfr > 0);
      chk("overflow", overflow, mdl_ovf);
      chk("drop_count", drop_count, mdl_drops);
      if (nfr > 0) begin
        chk("m_bin", m_bin, idx);
        chk("m_real", m_real, qr[idx]);
        chk("m_imag", m_imag, qi[idx]);
        chk("m_last", m_last, idx == 63);
      end
      if (overflow) ovf_pulses++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_frame(input int base);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        frame_real[r][c] = 16'(base + r + 8 * c);
        frame_imag[r][c] = 16'(-(base + r + 8 * c));
      end
    frame_valid = 1'b1;
  endtask

  task automatic pulse_frame(input int base);
    drive_frame(base);
    tick();
    frame_valid = 1'b0;
  endtask

  task automatic drain(input bit rnd, output int beats);
    beats = 0;
    for (int i = 0; i < 2000; i++) begin
      if (!m_valid) break;
      if (rnd) m_ready = 1'($urandom_range(0, 1));
      if (m_ready) beats++;
      tick();
    end
    if (m_valid) chk("drain_timeout", 1, 0);
    m_ready = 1'b1;
  endtask

  task automatic wait_bin(input int b);
    for (int i = 0; i < 400; i++) begin
      if (m_valid && m_bin == 6'(b)) break;
      tick();
    end
    if (!(m_valid && m_bin == 6'(b))) chk("wait_bin_timeout", m_bin, b);
  endtask

  initial begin
    int beats;
    int n;
    sreset = 1'b1;
    frame_valid = 1'b0;
    frame_real = '0;
    frame_imag = '0;
    m_ready = 1'b0;
    tick();
    tick();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_m_bin", m_bin, 0);
    chk("rst_m_real", m_real, 0);
    chk("rst_m_imag", m_imag, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop_count", drop_count, 0);
    sreset = 1'b0;
    chk_en = 1'b1;
    tick();

    // single frame, full rate
    m_ready = 1'b1;
    pulse_frame(0);
    chk("lat_m_valid", m_valid, 1);
    chk("lat_m_bin", m_bin, 0);
    chk("mdl_real_b5", qr[5], 5);
    chk("mdl_imag_b5", qi[5], 16'hFFFB);
    chk("mdl_real_b9", qr[9], 9);
    n = 0;
    beats = 0;
    for (int i = 0; i < 200; i++) begin
      if (!m_valid) break;
      beats++;
      if (m_last) n++;
      if (m_bin == 6'd5) begin
        chk("b5_real", m_real, 5);
        chk("b5_imag", m_imag, 16'hFFFB);
      end
      if (m_bin == 6'd63) chk("b63_last", m_last, 1);
      tick();
    end
    chk("single_beats", beats, 64);
    chk("single_last_cnt", n, 1);
    chk("single_busy_after", busy, 0);

    // random backpressure
    tick();
    pulse_frame(100);
    drain(1'b1, beats);
    chk("bp_beats", beats, 64);

    // two frames three cycles apart, contiguous output
    tick();
    ovf_pulses = 0;
    pulse_frame(200);
    n = 0;
    repeat (2) begin
      n += int'(m_valid);
      tick();
    end
    n += int'(m_valid);
    drive_frame(1000);
    tick();
    frame_valid = 1'b0;
    drain(1'b0, beats);
    chk("two_frame_beats", n + beats, 128);
    chk("two_frame_ovf", ovf_pulses, 0);

    // three back-to-back frames while stalled: third dropped
    tick();
    m_ready = 1'b0;
    ovf_pulses = 0;
    drive_frame(300);
    tick();
    drive_frame(400);
    tick();
    drive_frame(500);
    tick();
    frame_valid = 1'b0;
    tick();
    chk("drop1_count", drop_count, 1);
    chk("drop1_pulses", ovf_pulses, 1);
    chk("drop1_busy", busy, 1);
    m_ready = 1'b1;
    drain(1'b0, beats);
    chk("drop1_beats", beats, 128);

    // saturate the drop counter
    m_ready = 1'b0;
    for (int i = 0; i < 302; i++) begin
      drive_frame(i * 3);
      tick();
    end
    frame_valid = 1'b0;
    tick();
    chk("drop_sat", drop_count, 255);

    // reset in the middle of a frame
    m_ready = 1'b1;
    wait_bin(30);
    sreset = 1'b1;
    tick();
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_drop", drop_count, 0);
    sreset = 1'b0;
    tick();
    pulse_frame(900);
    chk("post_rst_valid", m_valid, 1);
    chk("post_rst_bin", m_bin, 0);
    chk("post_rst_real", m_real, 900);
    drain(1'b0, beats);
    chk("post_rst_beats", beats, 64);

    // frame arriving on the last-beat handshake with both buffers full
    tick();
    ovf_pulses = 0;
    m_ready = 1'b0;
    drive_frame(600);
    tick();
    drive_frame(700);
    tick();
    frame_valid = 1'b0;
    tick();
    m_ready = 1'b1;
    wait_bin(63);
    drive_frame(800);
    tick();
    frame_valid = 1'b0;
    chk("edge_next_bin", m_bin, 0);
    chk("edge_next_real", m_real, 700);
    chk("edge_drop", drop_count, 0);
    drain(1'b0, beats);
    chk("edge_beats", beats, 128);
    chk("edge_ovf", ovf_pulses, 0);

    tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
